// File: rtl/bp_be_acc_wide_collector.sv
// Collects fill-width beats (optionally critical-beat-first, wrapping) into one block-width word
// and emits it as a registered single-cycle pulse. Optional framing check: BP_BE_ACC_COLLECTOR_CHECK_EN.
module bp_be_acc_wide_collector #(
  parameter int fill_width_p  = 64,
  parameter int block_width_p = 512,
  localparam int beats_lp     = block_width_p / fill_width_p,
  localparam int cnt_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [fill_width_p-1:0]  beat_data_i,
  input  logic [cnt_width_lp-1:0]  beat_offset_i,
  input  logic                     beat_last_i,
  input  logic                     beat_v_i,
  output logic                     beat_ready_and_o,
  output logic [block_width_p-1:0] wide_data_o,
  output logic                     wide_v_o,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam logic [cnt_width_lp-1:0] cnt_last_lp = cnt_width_lp'(beats_lp - 1);
  localparam logic [cnt_width_lp-1:0] cnt_one_lp  = cnt_width_lp'(1);
  localparam logic [cnt_width_lp-1:0] cnt_zero_lp = cnt_width_lp'(0);

  typedef enum logic [0:0] {
    e_idle    = 1'b0,
    e_collect = 1'b1
  } state_e;

  state_e                   state_r;
  logic [block_width_p-1:0] assembly_r;
  logic [block_width_p-1:0] data_r;
  logic [block_width_p-1:0] merged_s;
  logic [cnt_width_lp-1:0]  start_r;
  logic [cnt_width_lp-1:0]  cnt_r;
  logic [cnt_width_lp-1:0]  slot_s;
  logic                     wide_v_r;
  logic                     accept_s;
  logic                     complete_s;

  // Separate assembly and output registers let the collector accept every cycle.
  assign beat_ready_and_o = ~reset_i;
  assign accept_s         = beat_v_i & ~reset_i;

  assign wide_data_o = data_r;
  assign wide_v_o    = wide_v_r;
  assign busy_o      = (state_r == e_collect);

  // Target slot of the incoming beat and whether it finishes the block.
  always_comb begin
    slot_s     = cnt_zero_lp;
    complete_s = 1'b0;
    case (state_r)
      e_idle: begin
        slot_s     = beat_offset_i;
        complete_s = 1'b0;
      end
      e_collect: begin
        slot_s     = cnt_width_lp'(start_r + cnt_r);
        complete_s = (cnt_r == cnt_last_lp);
      end
      default: begin
        slot_s     = cnt_zero_lp;
        complete_s = 1'b0;
      end
    endcase
  end

  // Assembly contents with the current beat merged into its slot.
  always_comb begin
    merged_s = assembly_r;
    merged_s[slot_s*fill_width_p +: fill_width_p] = beat_data_i;
  end

`ifdef BP_BE_ACC_COLLECTOR_CHECK_EN
  logic err_r;
  logic frame_err_s;

  // A last flag must appear exactly on the completing beat.
  assign frame_err_s = accept_s & (beat_last_i ^ complete_s);
  assign err_o       = err_r;

  // Sticky framing error flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_r <= 1'b0;
    end else if (frame_err_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`else
  logic frame_err_s;
  logic unused_last_s;

  assign frame_err_s   = 1'b0;
  assign unused_last_s = beat_last_i;
  assign err_o         = 1'b0;
`endif

  // Collector FSM with assembly, output and pulse registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_idle;
      assembly_r <= '0;
      data_r     <= '0;
      start_r    <= cnt_zero_lp;
      cnt_r      <= cnt_zero_lp;
      wide_v_r   <= 1'b0;
    end else begin
      wide_v_r <= 1'b0;
      if (accept_s) begin
        assembly_r <= merged_s;
        if (frame_err_s) begin
          // Badly framed block is dropped; the next beat starts a fresh one.
          state_r <= e_idle;
          cnt_r   <= cnt_zero_lp;
        end else begin
          case (state_r)
            e_idle: begin
              start_r <= beat_offset_i;
              cnt_r   <= cnt_one_lp;
              state_r <= e_collect;
            end
            e_collect: begin
              if (complete_s) begin
                data_r   <= merged_s;
                wide_v_r <= 1'b1;
                cnt_r    <= cnt_zero_lp;
                state_r  <= e_idle;
              end else begin
                cnt_r <= cnt_r + cnt_one_lp;
              end
            end
            default: begin
              cnt_r   <= cnt_zero_lp;
              state_r <= e_idle;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bp_be_acc_wide_collector.sv
// Directed self-checking bench for bp_be_acc_wide_collector (8 x 64-bit beats per 512-bit block).
module tb_bp_be_acc_wide_collector;
  localparam int FW = 64;
  localparam int BW = 512;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [FW-1:0] beat_data_i;
  logic [2:0]    beat_offset_i;
  logic          beat_last_i;
  logic          beat_v_i;
  logic          beat_ready_and_o;
  logic [BW-1:0] wide_data_o;
  logic          wide_v_o;
  logic          busy_o;
  logic          err_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc = 0;

  bp_be_acc_wide_collector #(.fill_width_p(FW), .block_width_p(BW)) dut (
    .clk_i(clk), .reset_i(reset_i), .beat_data_i(beat_data_i), .beat_offset_i(beat_offset_i),
    .beat_last_i(beat_last_i), .beat_v_i(beat_v_i), .beat_ready_and_o(beat_ready_and_o),
    .wide_data_o(wide_data_o), .wide_v_o(wide_v_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wide_v_o) begin
      pulses    <= pulses + 1;
      pulse_cyc <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] exp_block(input logic [FW-1:0] base, input int off);
    logic [BW-1:0] blk;
    blk = '0;
    for (int j = 0; j < NB; j++) blk[((off + j) % NB)*FW +: FW] = base + FW'(j);
    return blk;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [FW-1:0] d, input logic [2:0] off, input logic last);
    beat_v_i      = 1'b1;
    beat_data_i   = d;
    beat_offset_i = off;
    beat_last_i   = last;
    tick();
    beat_v_i      = 1'b0;
    beat_last_i   = 1'b0;
  endtask

  initial begin
    int p0;
    int pc1;
    int busy_cnt;
    logic [15:0] gap_pat;

    reset_i = 1'b1; beat_v_i = 1'b0; beat_data_i = '0; beat_offset_i = 3'd0; beat_last_i = 1'b0;
    tick();
    check_eq("rst_ready", beat_ready_and_o, 1'b0);
    check_eq("rst_wide_v", wide_v_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_err", err_o, 1'b0);
    check_eq("rst_data", wide_data_o, '0);
    tick();
    reset_i = 1'b0;
    #1;
    check_eq("ready_after_rst", beat_ready_and_o, 1'b1);

    // Aligned fill
    p0 = pulses; busy_cnt = 0;
    for (int j = 0; j < NB; j++) begin
      send_beat(FW'(j), 3'd0, j == NB-1);
      busy_cnt += int'(busy_o);
    end
    check_eq("align_busy_cycles", busy_cnt, 7);
    check_eq("align_wide_v", wide_v_o, 1'b1);
    check_eq("align_data", wide_data_o, exp_block(64'h0, 0));
    check_eq("align_slot3", wide_data_o[3*FW +: FW], 64'h3);
    tick();
    check_eq("align_pulse_width", wide_v_o, 1'b0);
    check_eq("align_pulse_count", pulses - p0, 1);
    check_eq("align_data_hold", wide_data_o, exp_block(64'h0, 0));

    // Wrapped fill; offsets on non-first beats are junk and must be ignored
    for (int j = 0; j < NB; j++) send_beat(64'hA0 + FW'(j), (j == 0) ? 3'd5 : 3'(j * 3), j == NB-1);
    check_eq("wrap_wide_v", wide_v_o, 1'b1);
    check_eq("wrap_slot0", wide_data_o[0 +: FW], 64'hA3);
    check_eq("wrap_slot5", wide_data_o[5*FW +: FW], 64'hA0);
    check_eq("wrap_data", wide_data_o, exp_block(64'hA0, 5));
    tick();

    // Back-to-back blocks
    for (int j = 0; j < NB; j++) send_beat(64'h10 + FW'(j), 3'd0, j == NB-1);
    check_eq("b2b_first_v", wide_v_o, 1'b1);
    check_eq("b2b_first_data", wide_data_o, exp_block(64'h10, 0));
    send_beat(64'h20, 3'd3, 1'b0);
    pc1 = pulse_cyc;
    check_eq("b2b_overlap_v", wide_v_o, 1'b0);
    check_eq("b2b_overlap_hold", wide_data_o, exp_block(64'h10, 0));
    for (int j = 1; j < NB; j++) send_beat(64'h20 + FW'(j), 3'd1, j == NB-1);
    check_eq("b2b_second_v", wide_v_o, 1'b1);
    check_eq("b2b_second_data", wide_data_o, exp_block(64'h20, 3));
    tick();
    check_eq("b2b_pulse_spacing", pulse_cyc - pc1, 8);

    // Gaps in beat_v_i: 8 valid cycles among 13
    p0 = pulses;
    gap_pat = 16'b0001_1011_0100_1101;
    begin
      int k;
      k = 0;
      for (int c = 0; c < 13; c++) begin
        if (gap_pat[c]) begin
          send_beat(64'h40 + FW'(k), (k == 0) ? 3'd6 : 3'd7, k == NB-1);
          k++;
        end else begin
          beat_data_i = 64'hDEAD; beat_offset_i = 3'd7; beat_last_i = 1'b1;
          tick();
          beat_last_i = 1'b0;
        end
      end
    end
    check_eq("gap_wide_v", wide_v_o, 1'b1);
    check_eq("gap_data", wide_data_o, exp_block(64'h40, 6));
    tick();
    check_eq("gap_pulse_count", pulses - p0, 1);

    // Reset mid-block
    p0 = pulses;
    for (int j = 0; j < 4; j++) send_beat(64'hE0 + FW'(j), 3'd1, 1'b0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check_eq("midrst_busy", busy_o, 1'b0);
    for (int j = 0; j < NB; j++) send_beat(64'h30 + FW'(j), 3'd2, j == NB-1);
    check_eq("midrst_data", wide_data_o, exp_block(64'h30, 2));
    tick();
    check_eq("midrst_pulse_count", pulses - p0, 1);

    // Reset coincident with the completing beat
    p0 = pulses;
    for (int j = 0; j < NB-1; j++) send_beat(64'h50 + FW'(j), 3'd0, 1'b0);
    reset_i = 1'b1;
    send_beat(64'h57, 3'd0, 1'b1);
    reset_i = 1'b0;
    check_eq("rstcmp_wide_v", wide_v_o, 1'b0);
    check_eq("rstcmp_busy", busy_o, 1'b0);
    tick();
    check_eq("rstcmp_pulse_count", pulses - p0, 0);

    // Early last on the 3rd beat
    p0 = pulses;
    for (int j = 0; j < NB; j++) begin
      send_beat(64'h60 + FW'(j), 3'd0, j == 2);
`ifdef BP_BE_ACC_COLLECTOR_CHECK_EN
      if (j == 2) begin
        check_eq("frame_err_set", err_o, 1'b1);
        check_eq("frame_busy_cleared", busy_o, 1'b0);
      end
`endif
    end
`ifdef BP_BE_ACC_COLLECTOR_CHECK_EN
    check_eq("frame_no_pulse", wide_v_o, 1'b0);
    check_eq("frame_err_sticky", err_o, 1'b1);
    tick();
    check_eq("frame_pulse_count", pulses - p0, 0);
`else
    check_eq("frame_pulse", wide_v_o, 1'b1);
    check_eq("frame_data", wide_data_o, exp_block(64'h60, 0));
    check_eq("frame_err_zero", err_o, 1'b0);
    tick();
`endif
    for (int j = 0; j < NB; j++) send_beat(64'h70 + FW'(j), 3'd4, j == NB-1);
    check_eq("post_frame_v", wide_v_o, 1'b1);
    check_eq("post_frame_data", wide_data_o, exp_block(64'h70, 4));
`ifdef BP_BE_ACC_COLLECTOR_CHECK_EN
    check_eq("post_frame_err", err_o, 1'b1);
`else
    check_eq("post_frame_err", err_o, 1'b0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_be_acc_wide_collector.md
# bp_be_acc_wide_collector

Assembles a stream of fill-width beats from the BedRock memory reverse path into one full cache-block-width word for the accelerator pipe. The pipe's wide-data input is valid-only with no backpressure, so the output is a registered single-cycle pulse. Supports critical-beat-first fills whose beats wrap modulo the block. Sits directly upstream of the accelerator pipe's `wide_data_i`/`wide_v_i` inputs.

## Interface
- `fill_width_p`, 64, beat width in bits
- `block_width_p`, 512, assembled block width; must be a power-of-two multiple of `fill_width_p`
- Derived: `beats_lp` = `block_width_p`/`fill_width_p` (8 by default); `cnt_width_lp` = log2(`beats_lp`) (3 by default)

Ports:
- `clk_i` in 1: clock, single clock domain
- `reset_i` in 1: reset, synchronous, active-high
- `beat_data_i` in `fill_width_p`: beat payload
- `beat_offset_i` in `cnt_width_lp`: beat index of the first beat of a block; sampled only on the first beat
- `beat_last_i` in 1: sender marks the final beat of a block
- `beat_v_i` in 1: beat valid
- `beat_ready_and_o` out 1: ready; a beat transfers when `beat_v_i & beat_ready_and_o`
- `wide_data_o` out `block_width_p`: assembled block
- `wide_v_o` out 1: single-cycle valid pulse; the consumer cannot stall it
- `busy_o` out 1: a partial block is held
- `err_o` out 1: sticky framing error; tied to 0 unless `BP_BE_ACC_COLLECTOR_CHECK_EN` is defined

## Operation
- FSM states are `e_idle` and `e_collect`.
- Registers:
  - assembly register, `block_width_p` bits
  - output register, `block_width_p` bits
  - `start_r`, `cnt_r` (`cnt_width_lp` bits each)
  - `wide_v_r`, `err_r`
- `beat_ready_and_o` = ~`reset_i`. The block never stalls because the assembly and output registers are separate.
- `e_idle`, beat accepted:
  - `start_r` ← `beat_offset_i`
  - beat is written to slot `beat_offset_i`
  - `cnt_r` ← 1; go to `e_collect`
- `e_collect`, beat accepted:
  - slot = (`start_r` + `cnt_r`) mod `beats_lp`, wrapping with natural `cnt_width_lp`-bit overflow
  - `cnt_r` ← `cnt_r` + 1
- Completion: the beat accepted with `cnt_r` = `beats_lp`−1 completes the block.
  - output register ← assembly contents with the completing beat merged into its slot
  - `wide_v_r` ← 1
  - go to `e_idle`; `cnt_r` ← 0
- Slot k occupies bits [k·`fill_width_p` +: `fill_width_p`] of the block.
- Slots are not cleared between blocks; every slot is overwritten before completion.
- `busy_o` = (state == `e_collect`).
- Without `BP_BE_ACC_COLLECTOR_CHECK_EN`, `beat_last_i` is ignored and completion is purely count-based.

## Timing
- Throughput: 1 beat per cycle sustained. Back-to-back blocks need no gap cycles.
- Latency: `wide_v_o` rises the cycle after the completing beat is accepted, is high for exactly 1 cycle, and `wide_data_o` is valid in that same cycle.
- `wide_data_o` holds its value until the next completion. The consumer should use it only while `wide_v_o` is high.
- A beat accepted in the same cycle that `wide_v_o` is high belongs to the next block and does not disturb `wide_data_o`.
- Reset values:
  - state `e_idle`; `cnt_r` = 0; `start_r` = 0
  - `wide_v_o` = 0, `busy_o` = 0, `err_o` = 0
  - `wide_data_o` = 0; `beat_ready_and_o` = 0 while `reset_i` is high
- Reset mid-block discards the partial block, and no `wide_v_o` pulse is produced for it. Reset in the same cycle as completion suppresses the pulse.
- `beat_offset_i` is ignored on every beat except the first of a block.

## Configuration
- Macro: `BP_BE_ACC_COLLECTOR_CHECK_EN`.
- Defined, two framing checks apply. In both cases `err_r` ← 1 (sticky until reset) and no pulse is produced:
  - `beat_last_i` = 1 on a non-completing beat: the partial block is discarded and the FSM returns to `e_idle`.
  - `beat_last_i` = 0 on the completing beat: that block is discarded.
- Not defined:
  - `err_o` is constant 0
  - `beat_last_i` is unused
  - no check logic is synthesised

## Test plan
- **Aligned fill:** offset 0, beats 0x0..0x7 in consecutive cycles, last on the 8th → single `wide_v_o` pulse 1 cycle after beat 8; slot k = k; `busy_o` high for 7 cycles.
- **Wrapped fill:** offset 5, beats A0..A7 → slots 5,6,7,0,1,2,3,4 hold A0..A7, i.e. slot 0 = A3 and slot 5 = A0.
- **Back-to-back:** two blocks with no idle cycle (offsets 0 then 3) → two pulses 8 cycles apart; the first `wide_data_o` is unchanged while the second block's first beat is accepted.
- **Gaps:** `beat_v_i` deasserted randomly across 8 beats → exactly one pulse, data correct, `cnt_r` not advanced on idle cycles.
- **Reset mid-block:** accept 4 beats, assert `reset_i` for 1 cycle, then send a full block at offset 2 → only one pulse, containing the second block only; `busy_o` = 0 in the cycle after reset.
- **Framing check** (with `BP_BE_ACC_COLLECTOR_CHECK_EN`): `beat_last_i` on the 3rd beat → `err_o` = 1 the next cycle and stays 1, no pulse. A following well-formed block pulses normally. Without the macro, the same stimulus leaves `err_o` = 0, and the pulse follows the 8th beat.
